// File: rtl/riscv32ima_ifq.sv
// Instruction queue/aligner: buffers 64-bit fetch words and hands decode one
// 32-bit instruction per cycle, starting at the half selected by the fetch address.
module riscv32ima_ifq #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_valid,
   output logic                  fetch_ready,
   input  logic [ADDR_WIDTH-1:0] fetch_address,
   input  logic [DATA_WIDTH-1:0] fetch_data,
   input  logic                  wback_pc_wen,
   output logic                  decode_valid,
   input  logic                  decode_ready,
   output logic [ADDR_WIDTH-1:0] decode_pc,
   output logic [INST_WIDTH-1:0] decode_inst
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = ADDR_WIDTH - 3;

   // Entry storage is not reset; only the control state is.
   logic [TAG_W-1:0]      tag_mem   [DEPTH];
   logic                  start_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem  [DEPTH];

   logic [CNT_W-1:0] count_reg, count_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic             half_reg, half_next;

   logic             push;
   logic             consume;
   logic             pop;
   logic [PTR_W-1:0] rd_ptr_inc;
   logic [PTR_W-1:0] wr_ptr_inc;
   logic             unused_addr_bits;

   // Byte offset within an instruction carries no information for the queue.
   assign unused_addr_bits = ^fetch_address[1:0];

   assign fetch_ready  = (count_reg < CNT_W'(DEPTH));
   assign decode_valid = (count_reg != '0);

   assign push    = fetch_valid & fetch_ready & ~wback_pc_wen;
   assign consume = decode_valid & decode_ready;
   assign pop     = consume & half_reg;

   assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
   assign wr_ptr_inc = wr_ptr_reg + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr_reg]   <= fetch_address[ADDR_WIDTH-1:3];
         start_mem[wr_ptr_reg] <= fetch_address[2];
         data_mem[wr_ptr_reg]  <= fetch_data;
      end
   end

   always_comb begin
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      half_next   = half_reg;
      if (wback_pc_wen) begin
         count_next  = '0;
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         half_next   = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_inc;
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_inc;
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
         // The half pointer is reloaded whenever a new entry becomes head.
         if (pop) begin
            if (count_reg > CNT_W'(1)) begin
               half_next = start_mem[rd_ptr_inc];
            end else if (push) begin
               half_next = fetch_address[2];
            end else begin
               half_next = 1'b0;
            end
         end else if (consume) begin
            half_next = 1'b1;
         end else if (push && (count_reg == '0)) begin
            half_next = fetch_address[2];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         half_reg   <= 1'b0;
      end else begin
         count_reg  <= count_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         half_reg   <= half_next;
      end
   end

   always_comb begin
      decode_pc   = '0;
      decode_inst = '0;
      if (decode_valid) begin
         decode_pc   = {tag_mem[rd_ptr_reg], half_reg, 2'b00};
         decode_inst = half_reg ? data_mem[rd_ptr_reg][DATA_WIDTH-1:INST_WIDTH]
                                : data_mem[rd_ptr_reg][INST_WIDTH-1:0];
      end
   end

endmodule

// File: doc/riscv32ima_ifq.md
# riscv32ima_ifq

Instruction queue and aligner between the fetch stage and decode. Accepts 64-bit fetch words (two 32-bit instructions each) with their fetch address over a valid/ready handshake and buffers them in a small FIFO. Presents one 32-bit instruction per cycle with its PC to decode over a second valid/ready handshake. Discards all buffered words on a PC redirect from writeback.

## Interface

- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, fetch word width; fixed at 2 × INST_WIDTH
- INST_WIDTH, 32, instruction width
- DEPTH, 2, FIFO entries (fetch words); power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_valid  in  1  fetch word present
- fetch_ready  out  1  queue can accept a word this cycle
- fetch_address  in  ADDR_WIDTH  address of fetched word
- fetch_data  in  DATA_WIDTH  fetched word; bits [31:0] = instruction at {addr[31:3],3'b000}, bits [63:32] = instruction at +4
- wback_pc_wen  in  1  PC redirect; flush
- decode_valid  out  1  instruction available
- decode_ready  in  1  decode consumes this cycle
- decode_pc  out  ADDR_WIDTH  PC of presented instruction
- decode_inst  out  INST_WIDTH  presented instruction

## Operation

- FIFO entry: {addr[31:3], start_half, data[63:0]}; start_half = fetch_address[2]; fetch_address[1:0] ignored.
- Push when fetch_valid & fetch_ready & !wback_pc_wen.
- fetch_ready = (count < DEPTH), from registered count only; independent of decode_ready in the same cycle.
- Head half pointer `half`: loaded with start_half when an entry becomes head (push into empty, or pop exposing the next entry).
- decode_valid = (count != 0).
- decode_pc = {head.addr[31:3], half, 2'b00}.
- decode_inst = half ? head.data[63:32] : head.data[31:0].
- When decode_valid = 0: decode_pc = 0 and decode_inst = 0.
- Consume when decode_valid & decode_ready:
  - half = 0: half ← 1; entry retained.
  - half = 1: entry popped; count decrements unless a push occurs the same cycle.
- Push and pop in the same cycle: count unchanged. Permitted at count = DEPTH only if a push is not attempted; fetch_ready = 0 then.
- Pointers wrap modulo DEPTH.
- Flush: wback_pc_wen = 1 → next edge count = 0, pointers = 0, half = 0. An incoming fetch word and a decode consume in that cycle are both discarded; fetch still sees fetch_ready as driven.
- Reset (async, rst = 1): count = 0, pointers = 0, half = 0. Outputs: decode_valid = 0, decode_pc = 0, decode_inst = 0, fetch_ready = 1. Entry data is not reset.

## Timing

- Fill latency: a word pushed at edge N is visible on decode_* immediately after edge N, so 1 cycle from fetch_valid to decode_valid.
- Throughput: one instruction per cycle to decode. Two decode cycles per fetch word (one if start_half = 1).
- Sustained full rate with DEPTH = 2: fetch pushes at most every 2 cycles; no bubbles with decode_ready held at 1.
- Outputs change only after clk edges or on rst assertion; no combinational path from decode_ready or fetch_valid to any output.
- Redirect: decode_valid = 0 in the cycle after wback_pc_wen. The first post-redirect word is accepted in the next cycle.

## Test plan

- Reset mid-stream:
  - Stimulus: queue holds 2 words; assert rst asynchronously between edges.
  - Response: decode_valid = 0, decode_pc = 0, fetch_ready = 1 immediately, with no clock edge needed.
- Basic split:
  - Stimulus: push addr 0x1000_0000, data 0x0000_0093_0000_0013; decode_ready = 1.
  - Response: decode emits pc 0x1000_0000 / inst 0x0000_0013, then pc 0x1000_0004 / inst 0x0000_0093, then decode_valid = 0.
- Odd start:
  - Stimulus: push addr 0x1000_0014, data 0xAAAA_AAAA_BBBB_BBBB.
  - Response: single instruction, pc 0x1000_0014 / inst 0xAAAA_AAAA; the lower half is never presented.
- Backpressure/full:
  - Stimulus: decode_ready = 0; push 2 words.
  - Response: fetch_ready = 0 after the second push. A third fetch_valid is not accepted. Raise decode_ready: fetch_ready returns to 1 after the first word's upper half is consumed. Order is preserved.
- Flush with simultaneous push and consume:
  - Stimulus: queue holds 1 word at half = 1; in one cycle assert wback_pc_wen, fetch_valid with addr 0x2000_0000, and decode_ready.
  - Response: next cycle decode_valid = 0 and count = 0. A following push of 0x2000_0008 presents pc 0x2000_0008.
- Streaming:
  - Stimulus: 8 consecutive words from 0x1000_0000, fetch_valid held, decode_ready = 1.
  - Response: 16 instructions with PCs 0x1000_0000 through 0x1000_003C in +4 steps, no duplicates or drops.
